mem_controller: RTL and testbench
=================================

# mem_controller

Bus-side responder for the CPU control sequencer's memory handshake. It watches the one-hot control state, runs an instruction fetch during `STATE_FETCH` and a data load/store during `STATE_MEM`, and drives `mem_wait` back to the sequencer until the access completes. It sits between the core datapath and a simple req/ack memory bus, and performs byte-lane steering for 16-bit word and 8-bit byte accesses.

## Interface
Parameters:
- `ADDR_W`, 16: byte address width.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles; used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  core enable, same signal the sequencer uses.
- `control_i`  in  `CONTROL_BIT_MAX`+1  one-hot sequencer state.
- `pc_i`  in  `ADDR_W`  fetch address.
- `addr_i`  in  `ADDR_W`  data address.
- `wdata_i`  in  16  store data.
- `we_i`  in  1  1 = store, 0 = load (MEM only).
- `byte_i`  in  1  1 = byte access (MEM only).
- `mem_wait`  out  1  access in progress; sequencer holds FETCH/MEM.
- `instr_o`  out  16  latched instruction word.
- `rdata_o`  out  16  latched load data.
- `bus_req`  out  1  bus request.
- `bus_addr`  out  `ADDR_W`-1  word address (byte address >> 1).
- `bus_we`  out  1  write strobe.
- `bus_be`  out  2  byte enables; [1] = high byte.
- `bus_wdata`  out  16  write data.
- `bus_rdata`  in  16  read data, valid with `bus_ack`.
- `bus_ack`  in  1  completion, one cycle.
- `bus_err`  out  1  one-cycle timeout pulse (0 without `MEM_TIMEOUT_EN`).

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**: entered on reset.
  - With `en`=1 and `control_i` equal to `STATE_FETCH` or `STATE_MEM`, capture the address and controls and go to REQ.
  - FETCH captures `pc_i`, read, word.
  - MEM captures `addr_i`, `we_i`, `byte_i`, `wdata_i`.
- **REQ**: `bus_req`=1, and all bus outputs are held stable.
  - On `bus_ack`, latch `bus_rdata` into `instr_o` (fetch) or into `rdata_o` (load), then go to DONE.
  - A store latches nothing.
- **DONE**: `mem_wait`=0. Go to IDLE on the first cycle with `en`=1; otherwise stay in DONE.
- `mem_wait` = (`control_i` is FETCH or MEM) AND state ≠ DONE. It is combinational from the state register and `control_i`.
- Word access: `bus_be`=2'b11. Address bit 0 is ignored, so the access is forced aligned.
- Byte access:
  - `bus_be` = `addr[0]` ? 2'b10 : 2'b01.
  - Store replicates `wdata_i[7:0]` to both lanes.
  - Load zero-extends the selected lane into `rdata_o[7:0]`.
- Edge cases:
  - `bus_ack` while IDLE or DONE is ignored.
  - A `control_i` change while in REQ does not abort the access.
  - With `en`=0, REQ still completes on ack; IDLE does not start a new access.

## Timing
- Reset values: state IDLE, `bus_req` 0, `bus_we` 0, `bus_be` 0, `bus_addr` 0, `bus_wdata` 0, `instr_o` 0, `rdata_o` 0, `bus_err` 0.
- `mem_wait` is 0 out of reset, because `control_i`=0 after reset.
- Asserting `rst_n`=0 mid-access drops `bus_req` immediately and discards the access.
- Latency: the sequencer enters FETCH/MEM in cycle N, and `bus_req` rises in N+1.
  - Ack in N+1 (zero wait) gives DONE in N+2, so `mem_wait` is high in N and N+1 and low in N+2.
  - Each extra ack wait cycle adds one `mem_wait` cycle.
- `instr_o` and `rdata_o` are valid from the DONE cycle and hold until the next access latches new data.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter runs in REQ and clears on entry to REQ.
  - When it reaches `TIMEOUT_CYCLES` without ack: pulse `bus_err` for one cycle, load 16'hFFFF into the destination register (fetch or load), drop `bus_req`, and go to DONE.
- `MEM_TIMEOUT_EN` undefined: REQ waits indefinitely, `bus_err` is tied 0, and no counter is built.

## Structure
- `cpu_constants.vh` holds `CONTROL_BIT_MAX` and the `STATE_*` encodings consumed here.
- Add the `MEM_IDLE`/`MEM_REQ`/`MEM_DONE` encodings to the same header.
- One sub-module, `mem_lane_mux`: combinational write-lane replication, `bus_be` generation and read-lane zero-extension.

## Test plan
- Fetch, zero-wait: `control_i`=FETCH, `pc_i`=16'h0010, ack in the first REQ cycle with `bus_rdata`=16'hA5C3 -> `bus_addr`=15'h0008, `bus_be`=11, `mem_wait` high 2 cycles, `instr_o`=16'hA5C3.
- Load word, 3 wait cycles: `addr_i`=16'h0101 -> `bus_addr`=15'h0080, `mem_wait` high 5 cycles, `rdata_o`=`bus_rdata`.
- Byte store at 16'h0203 with `wdata_i`=16'h12AB -> `bus_be`=10, `bus_wdata`=16'hABAB, `bus_we`=1, `rdata_o` unchanged.
- Byte load at odd address, `bus_rdata`=16'h7F80 -> `rdata_o`=16'h007F.
- `rst_n` pulsed low mid-REQ -> `bus_req`=0 in the same cycle, all outputs at reset values, a later FETCH restarts cleanly.
- With `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, never ack -> `bus_err` one-cycle pulse, `instr_o`=16'hFFFF, `mem_wait` falls; without the macro, `mem_wait` stays high for 1000 cycles.

Source files
------------

// File: rtl/mem_controller_pkg.sv
// Shared encodings for the memory handshake: sequencer one-hot control states,
// the responder FSM states and the bus byte-enable patterns.
package mem_controller_pkg;

    localparam int CONTROL_BIT_MAX = 5;

    localparam logic [CONTROL_BIT_MAX:0] STATE_FETCH  = 6'b000001;
    localparam logic [CONTROL_BIT_MAX:0] STATE_DECODE = 6'b000010;
    localparam logic [CONTROL_BIT_MAX:0] STATE_EXEC   = 6'b000100;
    localparam logic [CONTROL_BIT_MAX:0] STATE_MEM    = 6'b001000;
    localparam logic [CONTROL_BIT_MAX:0] STATE_WB     = 6'b010000;
    localparam logic [CONTROL_BIT_MAX:0] STATE_HALT   = 6'b100000;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/mem_lane_mux.sv
// Byte-lane steering: byte-enable generation and store replication on the way out,
// zero-extension of the selected lane on the way back in.
module mem_lane_mux
    import mem_controller_pkg::*;
(
    input  logic        byte_i,
    input  logic        addr0_i,
    input  logic [15:0] wdata_i,
    output logic [1:0]  be_o,
    output logic [15:0] wdata_o,
    input  logic [1:0]  rd_be_i,
    input  logic [15:0] rdata_i,
    output logic [15:0] rdata_o
);

    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        if (byte_i) begin
            be_o    = addr0_i ? BE_HI : BE_LO;
            wdata_o = {wdata_i[7:0], wdata_i[7:0]};
        end
    end

    // The captured enables already tell which lane a byte load targets.
    always_comb begin
        case (rd_be_i)
            BE_HI:   rdata_o = {8'h00, rdata_i[15:8]};
            BE_LO:   rdata_o = {8'h00, rdata_i[7:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_controller.sv
// Bus-side responder for the sequencer's FETCH/MEM handshake over a req/ack bus.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [CONTROL_BIT_MAX:0] control_i,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [15:0]              wdata_i,
    input  logic                     we_i,
    input  logic                     byte_i,
    output logic                     mem_wait,
    output logic [15:0]              instr_o,
    output logic [15:0]              rdata_o,
    output logic                     bus_req,
    output logic [ADDR_W-2:0]        bus_addr,
    output logic                     bus_we,
    output logic [1:0]               bus_be,
    output logic [15:0]              bus_wdata,
    input  logic [15:0]              bus_rdata,
    input  logic                     bus_ack,
    output logic                     bus_err
);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              fetch_q, fetch_d;
    logic [1:0]        be_q, be_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              is_fetch, is_mem;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        lane_be;
    logic [15:0]       lane_wdata, lane_rdata;
    logic              timeout;

    assign is_fetch = (control_i == STATE_FETCH);
    assign is_mem   = (control_i == STATE_MEM);
    assign sel_addr = is_fetch ? pc_i : addr_i;

    mem_lane_mux u_lane (
        .byte_i  (is_mem & byte_i),
        .addr0_i (sel_addr[0]),
        .wdata_i (is_mem ? wdata_i : 16'h0000),
        .be_o    (lane_be),
        .wdata_o (lane_wdata),
        .rd_be_i (be_q),
        .rdata_i (bus_rdata),
        .rdata_o (lane_rdata)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts REQ cycles from zero; fires on the TIMEOUT_CYCLES-th one without ack.
    assign timeout = (state_q == MEM_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (state_q == MEM_REQ) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (en && (is_fetch || is_mem)) begin
                    state_d = MEM_REQ;
                    req_d   = 1'b1;
                    fetch_d = is_fetch;
                    we_d    = is_mem & we_i;
                    be_d    = lane_be;
                    addr_d  = sel_addr[ADDR_W-1:1];
                    wdata_d = lane_wdata;
                end
            end
            MEM_REQ: begin
                if (bus_ack) begin
                    state_d = MEM_DONE;
                    req_d   = 1'b0;
                    if (fetch_q)    instr_d = lane_rdata;
                    else if (!we_q) rdata_d = lane_rdata;
                end else if (timeout) begin
                    state_d = MEM_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (fetch_q)    instr_d = 16'hFFFF;
                    else if (!we_q) rdata_d = 16'hFFFF;
                end
            end
            MEM_DONE: begin
                if (en) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            instr_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_wait  = (is_fetch || is_mem) && (state_q != MEM_DONE);
    assign bus_req   = req_q;
    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign instr_o   = instr_q;
    assign rdata_o   = rdata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: a bus responder with programmable ack delay
// and a model that predicts bus signalling, latched data and mem_wait length.
module tb_mem_controller;
    import mem_controller_pkg::*;

    localparam int ADDR_W = 16;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     en;
    logic [CONTROL_BIT_MAX:0] control;
    logic [ADDR_W-1:0]        pc_i, addr_i;
    logic [15:0]              wdata_i;
    logic                     we_i, byte_i;
    logic                     mem_wait;
    logic [15:0]              instr_o, rdata_o;
    logic                     bus_req;
    logic [ADDR_W-2:0]        bus_addr;
    logic                     bus_we;
    logic [1:0]               bus_be;
    logic [15:0]              bus_wdata;
    logic [15:0]              bus_rdata = 16'h0000;
    logic                     bus_ack = 1'b0;
    logic                     bus_err;

    mem_controller #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .control_i (control),
        .pc_i      (pc_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .we_i      (we_i),
        .byte_i    (byte_i),
        .mem_wait  (mem_wait),
        .instr_o   (instr_o),
        .rdata_o   (rdata_o),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        fetch;
        logic [14:0] baddr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] result;
        int          wait_cycles;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_instr, m_rdata;

    int          ack_delay = 0;
    logic [15:0] rd_val = 16'h0000;
    logic        stray_ack = 1'b0;
    logic [15:0] stray_data = 16'h0000;
    int          req_cycles = 0;
    logic [33:0] first_bus = '0;
    logic [14:0] snap_addr = '0;
    logic [1:0]  snap_be = '0;
    logic        snap_we = 1'b0;
    logic [15:0] snap_wdata = '0;

    // Bus responder: acks after ack_delay REQ cycles; also checks the request stays stable.
    always @(negedge clk) begin
        if (bus_req) begin
            if (req_cycles == 0) first_bus = {bus_addr, bus_be, bus_we, bus_wdata};
            if (req_cycles == ack_delay) begin
                bus_ack    = 1'b1;
                bus_rdata  = rd_val;
                snap_addr  = bus_addr;
                snap_be    = bus_be;
                snap_we    = bus_we;
                snap_wdata = bus_wdata;
                check("bus_hold", {30'h0, bus_addr, bus_be, bus_we, bus_wdata}, {30'h0, first_bus});
            end else begin
                bus_ack = 1'b0;
            end
            req_cycles++;
        end else begin
            bus_ack    = stray_ack;
            bus_rdata  = stray_ack ? stray_data : 16'h0000;
            req_cycles = 0;
        end
    end

    task automatic access(input logic fetch, input logic [15:0] a, input logic [15:0] wd,
                          input logic we, input logic byt, input logic [15:0] rd, input int waits);
        exp_t e;
        exp_t g;
        int   cyc;
        e.fetch = fetch;
        e.baddr = a[15:1];
        e.be    = (fetch || !byt) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
        e.we    = !fetch && we;
        e.wdata = fetch ? 16'h0000 : (byt ? {wd[7:0], wd[7:0]} : wd);
        if (fetch) begin
            m_instr  = rd;
            e.result = rd;
        end else if (!we) begin
            m_rdata  = byt ? {8'h00, (a[0] ? rd[15:8] : rd[7:0])} : rd;
            e.result = m_rdata;
        end else begin
            e.result = m_rdata;
        end
        e.wait_cycles = 2 + waits;
        sb.push_back(e);

        @(negedge clk);
        ack_delay = waits;
        rd_val    = rd;
        control   = fetch ? STATE_FETCH : STATE_MEM;
        pc_i      = fetch ? a : 16'($urandom);
        addr_i    = fetch ? 16'($urandom) : a;
        wdata_i   = wd;
        we_i      = we;
        byte_i    = byt;
        cyc = 0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (!mem_wait) break;
            cyc++;
            @(negedge clk);
        end
        g = sb.pop_front();
        check("wait_cycles", 64'(cyc), 64'(g.wait_cycles));
        check("bus_addr", 64'(snap_addr), 64'(g.baddr));
        check("bus_be", 64'(snap_be), 64'(g.be));
        check("bus_we", 64'(snap_we), 64'(g.we));
        check("bus_wdata", 64'(snap_wdata), 64'(g.wdata));
        check("result", g.fetch ? 64'(instr_o) : 64'(rdata_o), 64'(g.result));
        if (g.fetch) check("rdata_kept", 64'(rdata_o), 64'(m_rdata));
        check("bus_req_done", 64'(bus_req), 64'd0);
        check("bus_err_done", 64'(bus_err), 64'd0);
        control = STATE_EXEC;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rf, rwe, rby;
        logic [15:0] ra, rw, rr;
        int          rwt;
        int          cyc;
        rst_n = 1'b0; en = 1'b1; control = '0; pc_i = '0; addr_i = '0;
        wdata_i = '0; we_i = 1'b0; byte_i = 1'b0;
        m_instr = 16'h0000; m_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_wait", 64'(mem_wait), 64'd0);
        check("rst_outputs", {bus_req, bus_we, bus_be, bus_addr, bus_wdata, instr_o, rdata_o, bus_err},
              64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'hA5C3, 0);
        check("tp_instr", 64'(instr_o), 64'hA5C3);
        access(1'b0, 16'h0101, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 3);
        access(1'b0, 16'h0203, 16'h12AB, 1'b1, 1'b1, 16'h0000, 1);
        access(1'b0, 16'h0203, 16'h0000, 1'b0, 1'b1, 16'h7F80, 0);
        check("tp_byte_load", 64'(rdata_o), 64'h007F);
        access(1'b0, 16'h0400, 16'h0000, 1'b0, 1'b1, 16'h7F80, 2);
        access(1'b0, 16'h0555, 16'hC3D4, 1'b1, 1'b0, 16'h0000, 0);
        for (int k = 0; k < 6; k++) begin
            rf  = 1'($urandom_range(0, 1));
            rwe = 1'($urandom_range(0, 1));
            rby = 1'($urandom_range(0, 1));
            ra  = 16'($urandom);
            rw  = 16'($urandom);
            rr  = 16'($urandom);
            rwt = $urandom_range(0, 3);
            access(rf, ra, rw, rwe, rby, rr, rwt);
        end

        // Ack pulses while idle must not latch anything.
        @(negedge clk); #1; stray_data = 16'h1234; stray_ack = 1'b1;
        @(negedge clk); #1; stray_ack = 1'b0;
        @(negedge clk); #1;
        check("stray_instr", 64'(instr_o), 64'(m_instr));
        check("stray_rdata", 64'(rdata_o), 64'(m_rdata));
        check("stray_req", 64'(bus_req), 64'd0);

        // Reset in the middle of an access.
        @(negedge clk);
        ack_delay = 1000; rd_val = 16'hDEAD; control = STATE_FETCH; pc_i = 16'h0020;
        @(negedge clk); @(negedge clk); #1;
        check("req_before_rst", 64'(bus_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_req", 64'(bus_req), 64'd0);
        check("rst_mid_outputs", {bus_we, bus_be, bus_addr, bus_wdata, instr_o, rdata_o, bus_err}, 64'd0);
        m_instr = 16'h0000; m_rdata = 16'h0000;
        control = STATE_EXEC;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        access(1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h55AA, 1);

        // Never-acked fetch.
        @(negedge clk);
        ack_delay = 100000; control = STATE_FETCH; pc_i = 16'h0030;
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (!mem_wait) break;
            cyc++;
            @(negedge clk);
        end
`ifdef MEM_TIMEOUT_EN
        check("tmo_wait", 64'(cyc), 64'(1 + TMO));
        check("tmo_err_pulse", 64'(bus_err), 64'd1);
        check("tmo_instr", 64'(instr_o), 64'hFFFF);
        check("tmo_req", 64'(bus_req), 64'd0);
        control = STATE_EXEC;
        @(negedge clk); #1;
        check("tmo_err_end", 64'(bus_err), 64'd0);
`else
        check("hang_wait", 64'(cyc), 64'd1000);
        check("hang_req", 64'(bus_req), 64'd1);
        check("hang_err", 64'(bus_err), 64'd0);
        rst_n = 1'b0;
        control = STATE_EXEC;
        @(negedge clk); rst_n = 1'b1;
`endif
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
